// File: rtl/ch_advert_tx.sv
// Cluster-head advertisement transmitter: serialises type, CH_ID, CH_Hops and CH_QValue onto the TX stream.
// Optional: define CHA_CHECKSUM_EN to append a fifth word holding the XOR of the first four.
module ch_advert_tx #(
  parameter int unsigned           WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] PKT_TYPE   = WORD_WIDTH'(16'h0003),
  parameter int unsigned           ADV_PERIOD = 64,
  parameter int unsigned           MAX_ADV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_CHA,
  input  logic                  HB_reset,
  input  logic [WORD_WIDTH-1:0] my_ID,
  input  logic [WORD_WIDTH-1:0] my_Hops,
  input  logic [WORD_WIDTH-1:0] my_QValue,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_last,
  output logic                  busy,
  output logic [7:0]            adv_count,
  output logic                  adv_done
);

  localparam int unsigned   PW        = $clog2(ADV_PERIOD);
  localparam logic [PW-1:0] PERIOD_M1 = PW'(ADV_PERIOD - 1);
  localparam logic [7:0]    MAX_C     = 8'(MAX_ADV);
`ifdef CHA_CHECKSUM_EN
  localparam logic [2:0]    LAST_IDX  = 3'd4;
`else
  localparam logic [2:0]    LAST_IDX  = 3'd3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  txValid_q, txValid_d;
  logic [WORD_WIDTH-1:0] txData_q, txData_d;
  logic                  txLast_q, txLast_d;
  logic                  busy_q, busy_d;
  logic [7:0]            advCount_q, advCount_d;
  logic                  advDone_q, advDone_d;
  logic [PW-1:0]         periodCnt_q, periodCnt_d;
  logic                  hbPend_q, hbPend_d;
  logic [WORD_WIDTH-1:0] id_q, id_d;
  logic [WORD_WIDTH-1:0] hops_q, hops_d;
  logic [WORD_WIDTH-1:0] qv_q, qv_d;
  logic [2:0]            wordIdx_q, wordIdx_d;

  logic [2:0]            nextIdx;
  logic [WORD_WIDTH-1:0] nextWord;
  logic [WORD_WIDTH-1:0] hopsSat;
  logic [7:0]            newCount;

  assign nextIdx  = wordIdx_q + 3'd1;
  assign newCount = advCount_q + 8'd1;
  assign hopsSat  = (&my_Hops) ? my_Hops : my_Hops + WORD_WIDTH'(1);

  // Next word to present once the current one is accepted; default slot is the checksum
  always_comb begin
    nextWord = PKT_TYPE ^ id_q ^ hops_q ^ qv_q;
    case (nextIdx)
      3'd0:    nextWord = PKT_TYPE;
      3'd1:    nextWord = id_q;
      3'd2:    nextWord = hops_q;
      3'd3:    nextWord = qv_q;
      default: nextWord = PKT_TYPE ^ id_q ^ hops_q ^ qv_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    txValid_d   = txValid_q;
    txData_d    = txData_q;
    txLast_d    = txLast_q;
    advCount_d  = advCount_q;
    advDone_d   = 1'b0;
    periodCnt_d = periodCnt_q;
    hbPend_d    = hbPend_q;
    id_d        = id_q;
    hops_d      = hops_q;
    qv_d        = qv_q;
    wordIdx_d   = wordIdx_q;

    case (state_q)
      S_IDLE: begin
        if (!en_CHA) advCount_d = 8'd0;
        if (HB_reset) begin
          advCount_d  = 8'd0;
          periodCnt_d = '0;
        end
        if (en_CHA && (HB_reset || (advCount_q < MAX_C))) state_d = S_LOAD;
      end

      S_LOAD: begin
        if (HB_reset) hbPend_d = 1'b1;
        id_d      = my_ID;
        hops_d    = hopsSat;
        qv_d      = my_QValue;
        txValid_d = 1'b1;
        txData_d  = PKT_TYPE;
        txLast_d  = 1'b0;
        wordIdx_d = 3'd0;
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (HB_reset) hbPend_d = 1'b1;
        if (tx_ready) begin
          if (wordIdx_q == LAST_IDX) begin
            txValid_d = 1'b0;
            txLast_d  = 1'b0;
            hbPend_d  = 1'b0;
            // A heartbeat seen mid-packet restarts the series instead of counting this advert
            if (hbPend_q || HB_reset) begin
              advCount_d = 8'd0;
              state_d    = en_CHA ? S_LOAD : S_IDLE;
            end else if (newCount == MAX_C) begin
              advCount_d = newCount;
              advDone_d  = 1'b1;
              state_d    = S_IDLE;
            end else if (!en_CHA) begin
              advCount_d = 8'd0;
              state_d    = S_IDLE;
            end else begin
              advCount_d  = newCount;
              periodCnt_d = PERIOD_M1;
              state_d     = S_WAIT;
            end
          end else begin
            wordIdx_d = nextIdx;
            txData_d  = nextWord;
            txLast_d  = (nextIdx == LAST_IDX);
          end
        end
      end

      S_WAIT: begin
        if (!en_CHA) begin
          advCount_d = 8'd0;
          state_d    = S_IDLE;
        end else if (HB_reset) begin
          advCount_d  = 8'd0;
          periodCnt_d = '0;
          state_d     = S_LOAD;
        end else if (periodCnt_q == '0) begin
          state_d = S_LOAD;
        end else begin
          periodCnt_d = periodCnt_q - PW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      txValid_q   <= 1'b0;
      txData_q    <= '0;
      txLast_q    <= 1'b0;
      busy_q      <= 1'b0;
      advCount_q  <= 8'd0;
      advDone_q   <= 1'b0;
      periodCnt_q <= '0;
      hbPend_q    <= 1'b0;
      id_q        <= '0;
      hops_q      <= '0;
      qv_q        <= '0;
      wordIdx_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      txValid_q   <= txValid_d;
      txData_q    <= txData_d;
      txLast_q    <= txLast_d;
      busy_q      <= busy_d;
      advCount_q  <= advCount_d;
      advDone_q   <= advDone_d;
      periodCnt_q <= periodCnt_d;
      hbPend_q    <= hbPend_d;
      id_q        <= id_d;
      hops_q      <= hops_d;
      qv_q        <= qv_d;
      wordIdx_q   <= wordIdx_d;
    end
  end

  assign tx_valid  = txValid_q;
  assign tx_data   = txData_q;
  assign tx_last   = txLast_q;
  assign busy      = busy_q;
  assign adv_count = advCount_q;
  assign adv_done  = advDone_q;

endmodule

// File: tb/tb_ch_advert_tx.sv
// Randomised self-checking bench for ch_advert_tx: packet contents are scored against
// words computed from the advert format, and timing is checked relative to observed events.
module tb_ch_advert_tx;

  localparam int ADV_PERIOD = 64;
  localparam int MAX_ADV    = 4;
`ifdef CHA_CHECKSUM_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic        clk;
  logic        rst;
  logic        en_CHA;
  logic        HB_reset;
  logic [15:0] my_ID;
  logic [15:0] my_Hops;
  logic [15:0] my_QValue;
  logic        tx_ready;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        busy;
  logic [7:0]  adv_count;
  logic        adv_done;

  ch_advert_tx dut (
    .clk       (clk),
    .rst       (rst),
    .en_CHA    (en_CHA),
    .HB_reset  (HB_reset),
    .my_ID     (my_ID),
    .my_Hops   (my_Hops),
    .my_QValue (my_QValue),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .busy      (busy),
    .adv_count (adv_count),
    .adv_done  (adv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int doneCount   = 0;
  int lastHsEdge  = 0;
  int firstHsEdge = 0;

  logic [15:0] rxData[$];
  logic        rxLast[$];
  int          rxEdge[$];
  int          riseQ[$];

  logic        prevValid = 1'b0;
  logic        prevReady = 1'b0;
  logic [15:0] prevData  = '0;
  logic        prevLast  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Advert word i derived from the node values presented when the advert was loaded
  function automatic logic [15:0] expWord(input int i, input logic [15:0] id, input logic [15:0] hops,
                                          input logic [15:0] q);
    int h;
    logic [15:0] ha;
    h = int'(hops) + 1;
    if (h > 65535) h = 65535;
    ha = 16'(h);
    case (i)
      0:       return 16'h0003;
      1:       return id;
      2:       return ha;
      3:       return q;
      default: return 16'h0003 ^ id ^ ha ^ q;
    endcase
  endfunction

  // Observes the stream between edges: records handshakes, valid rises, done pulses and stall stability
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
      prevReady = 1'b0;
    end else begin
      if (prevValid && !prevReady) begin
        checkOutput("holdValid", 32'(tx_valid), 32'd1);
        checkOutput("holdData", 32'(tx_data), 32'(prevData));
        checkOutput("holdLast", 32'(tx_last), 32'(prevLast));
      end
      if (tx_valid && !prevValid) riseQ.push_back(cyc);
      if (tx_valid && tx_ready) begin
        rxData.push_back(tx_data);
        rxLast.push_back(tx_last);
        rxEdge.push_back(cyc + 1);
      end
      if (adv_done) doneCount++;
      prevValid = tx_valid;
      prevReady = tx_ready;
      prevData  = tx_data;
      prevLast  = tx_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic hb, input logic rdy,
                               input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
    en_CHA    = en;
    HB_reset  = hb;
    tx_ready  = rdy;
    my_ID     = id;
    my_Hops   = hops;
    my_QValue = q;
  endtask

  task automatic checkRise(input string tag, input int expEdge);
    int waited = 0;
    while (riseQ.size() == 0 && waited < 300) begin
      tick(1);
      waited++;
    end
    checkOutput({tag, "_seen"}, 32'(riseQ.size() != 0), 32'd1);
    if (riseQ.size() != 0) checkOutput(tag, 32'(riseQ.pop_front()), 32'(expEdge));
  endtask

  task automatic checkPacket(input string tag, input logic [15:0] id, input logic [15:0] hops,
                             input logic [15:0] q, input bit randReady);
    int waited = 0;
    while (rxData.size() < NW && waited < 300) begin
      if (randReady) tx_ready = ($urandom_range(0, 3) != 0);
      tick(1);
      waited++;
    end
    tx_ready = 1'b1;
    checkOutput({tag, "_complete"}, 32'(rxData.size() >= NW), 32'd1);
    if (rxData.size() >= NW) begin
      firstHsEdge = rxEdge[0];
      for (int i = 0; i < NW; i++) begin
        checkOutput($sformatf("%s_word%0d", tag, i), 32'(rxData.pop_front()), 32'(expWord(i, id, hops, q)));
        checkOutput($sformatf("%s_last%0d", tag, i), 32'(rxLast.pop_front()), 32'(i == NW - 1));
        lastHsEdge = rxEdge.pop_front();
      end
    end
  endtask

  initial begin
    int enCyc;
    int waited;
    logic [15:0] id2, hops2, q2, rid, rhops, rq;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
    tick(3);
    checkOutput("rstValid", 32'(tx_valid), 32'd0);
    checkOutput("rstData", 32'(tx_data), 32'd0);
    checkOutput("rstLast", 32'(tx_last), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstCount", 32'(adv_count), 32'd0);
    checkOutput("rstDone", 32'(adv_done), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("[TB] full series with en_CHA held");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0002, 16'h1234);
    enCyc = cyc;
    checkRise("firstRise", enCyc + 2);
    id2   = 16'($urandom);
    hops2 = 16'($urandom);
    q2    = 16'($urandom);
    applyStimulus(1'b1, 1'b0, 1'b1, id2, hops2, q2);
    checkPacket("adv1", 16'h0005, 16'h0002, 16'h1234, 1'b0);
    checkOutput("adv1NoBubble", 32'(lastHsEdge - firstHsEdge), 32'(NW - 1));
    for (int k = 2; k <= MAX_ADV; k++) begin
      checkRise($sformatf("adv%0dGap", k), lastHsEdge + ADV_PERIOD + 1);
      checkPacket($sformatf("adv%0d", k), id2, hops2, q2, 1'b1);
    end
    tick(2);
    checkOutput("seriesCount", 32'(adv_count), 32'(MAX_ADV));
    checkOutput("seriesDone", 32'(doneCount), 32'd1);
    checkOutput("seriesIdle", 32'(busy), 32'd0);
    tick(150);
    checkOutput("noExtraWords", 32'(rxData.size()), 32'd0);
    checkOutput("noExtraRise", 32'(riseQ.size()), 32'd0);

    $display("[TB] heartbeat restart and backpressure");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0005, 16'h0002, 16'h1234);
    enCyc = cyc;
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0002, 16'h1234);
    checkOutput("hbCountClr", 32'(adv_count), 32'd0);
    checkRise("hbRise", enCyc + 2);
    waited = 0;
    while (rxData.size() < 1 && waited < 50) begin
      tick(1);
      waited++;
    end
    tx_ready = 1'b0;
    tick(3);
    tx_ready = 1'b1;
    checkPacket("stall", 16'h0005, 16'h0002, 16'h1234, 1'b0);
    checkOutput("hbCountFrom0", 32'(adv_count), 32'd1);
    checkOutput("waitBusy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0002, 16'h1234);
    tick(2);
    checkOutput("dropWaitBusy", 32'(busy), 32'd0);
    checkOutput("dropWaitCount", 32'(adv_count), 32'd0);

    $display("[TB] saturated hops with en_CHA dropped mid-packet");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'hFFFF, 16'h0F0F);
    enCyc = cyc;
    checkRise("satRise", enCyc + 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, 16'hFFFF, 16'h0F0F);
    checkPacket("sat", 16'hBEEF, 16'hFFFF, 16'h0F0F, 1'b0);
    tick(2);
    checkOutput("dropBusy", 32'(busy), 32'd0);
    checkOutput("dropCount", 32'(adv_count), 32'd0);
    checkOutput("dropNoDone", 32'(doneCount), 32'd1);

    $display("[TB] zero hops with heartbeat during send");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h00A1, 16'h0000, 16'h7777);
    enCyc = cyc;
    checkRise("zeroRise", enCyc + 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h00A1, 16'h0000, 16'h7777);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h00A1, 16'h0000, 16'h7777);
    checkPacket("zero", 16'h00A1, 16'h0000, 16'h7777, 1'b0);
    checkOutput("hbPendNoInc", 32'(adv_count), 32'd0);
    checkRise("hbPendRestart", lastHsEdge + 1);
    checkPacket("hbPendPkt", 16'h00A1, 16'h0000, 16'h7777, 1'b0);
    checkOutput("hbPendCount", 32'(adv_count), 32'd1);
    checkOutput("hbPendNoDone", 32'(doneCount), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);

    $display("[TB] randomised single adverts");
    for (int n = 0; n < 8; n++) begin
      tick(3);
      rid   = 16'($urandom);
      rhops = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rq    = 16'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b1, rid, rhops, rq);
      enCyc = cyc;
      checkRise($sformatf("rnd%0dRise", n), enCyc + 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
      checkPacket($sformatf("rnd%0d", n), rid, rhops, rq, 1'b1);
      tick(2);
      checkOutput($sformatf("rnd%0dIdle", n), 32'(busy), 32'd0);
      checkOutput($sformatf("rnd%0dCount", n), 32'(adv_count), 32'd0);
    end

    $display("[TB] reset in the middle of a packet");
    tick(2);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h1111, 16'h0003, 16'h2222);
    enCyc = cyc;
    checkRise("rstMidRise", enCyc + 2);
    tx_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstMidValid", 32'(tx_valid), 32'd0);
    checkOutput("rstMidLast", 32'(tx_last), 32'd0);
    checkOutput("rstMidBusy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
    tick(1);
    rst = 1'b0;
    rxData.delete();
    rxLast.delete();
    rxEdge.delete();
    riseQ.delete();
    tick(10);
    checkOutput("rstNoResume", 32'(rxData.size()), 32'd0);
    checkOutput("rstNoRise", 32'(riseQ.size()), 32'd0);
    checkOutput("finalDone", 32'(doneCount), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
